auto_breaker: RTL and testbench
===============================

AUTO_BREAKER -- requirements
Module: auto_breaker

Interface
REQ-001 The block SHALL have parameter MAX_TURNS, default 8, meaning the history depth and turn limit, legal range 1..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a pulse that begins a new game.
REQ-005 The block SHALL have ports guess0, guess1, guess2, guess3, output, 3 bits each: the offered code, one colour per slot.
REQ-006 The block SHALL have port guess_valid, output, 1 bit: the offered code is valid.
REQ-007 The block SHALL have port guess_ready, input, 1 bit: the consumer accepts the offered code.
REQ-008 The block SHALL have ports fb_valid, input, 1 bit; fb_black, input, 3 bits; fb_white, input, 3 bits: the scoring result for the last accepted guess.
REQ-009 The block SHALL have ports busy, solved and failed, output, 1 bit each, and port turn, output, 4 bits: the count of completed turns.

Function
REQ-010 Candidate encoding SHALL be a 12-bit counter cand, with guess3=cand[11:9], guess2=cand[8:6], guess1=cand[5:3] and guess0=cand[2:0].
REQ-011 The states SHALL be IDLE, SEARCH, OFFER, WAIT_FB, SOLVED and FAILED; busy=1 in SEARCH, OFFER and WAIT_FB only.
REQ-012 start in any state SHALL clear the history, set cand=0 and turn=0, clear solved and failed, and enter SEARCH.
REQ-013 SEARCH SHALL check one history entry per cycle, entries 0..turn-1 in order.
REQ-014 An entry SHALL match when the score of (cand, stored guess) equals the stored (black, white).
REQ-015 Score rules:
- black = number of slots with equal colour.
- white = (sum over the 8 colours of the minimum of the two per-colour counts) - black.
- Computed combinationally, 3-bit results.
REQ-016 On a mismatch, SEARCH SHALL increment cand, restart at entry 0, and spend 1 cycle per checked entry.
REQ-017 When all entries match, or when turn=0 (1 cycle), the block SHALL enter OFFER with cand unchanged.
REQ-018 A mismatch at cand=4095 SHALL enter FAILED; cand SHALL NOT wrap.
REQ-019 In OFFER, guess_valid SHALL be 1 and guess0..3 SHALL be held stable until guess_ready=1 is sampled.
REQ-020 On acceptance, the block SHALL write the guess into history[turn], deassert guess_valid in the next cycle, and enter WAIT_FB.
REQ-021 In WAIT_FB, on fb_valid=1 the block SHALL store fb_black and fb_white into history[turn]; fb_valid in any other state SHALL be ignored.
REQ-022 On stored fb_black=4, the block SHALL enter SOLVED with solved=1, guess0..3 held, and turn unchanged.
REQ-023 Otherwise the block SHALL increment turn; if turn now equals MAX_TURNS it SHALL enter FAILED, else it SHALL increment cand and enter SEARCH.
REQ-024 Feedback with black+white>4 SHALL be stored unchanged; the search then simply finds no match.
REQ-025 start and fb_valid in the same cycle: start SHALL win and the feedback SHALL be discarded.
REQ-026 SOLVED and FAILED SHALL be held until start or reset; solved and failed SHALL never both be 1.
REQ-027 guess_valid SHALL be 0 in every state except OFFER.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE; guess_valid=0, guess0..3=0, busy=0, solved=0, failed=0, turn=0, cand=0, and history cleared.
REQ-029 reset SHALL take priority over start and all handshakes, including mid-SEARCH and mid-OFFER.

Configuration
REQ-030 With macro AUTO_BREAKER_OPENING_GUESS_EN defined:
- start SHALL enter OFFER directly with guess3=0, guess2=0, guess1=1, guess0=1 (cand=0x009), with no search cycles.
- Subsequent searches SHALL begin at cand=0x00A.
REQ-031 Without AUTO_BREAKER_OPENING_GUESS_EN, the first guess SHALL come from SEARCH at cand=0 (0,0,0,0).

Verification
REQ-032 No macro: start, guess_ready=1, feedback black=4 white=0 -> first offer is 0,0,0,0; solved=1, turn=0, busy=0.
REQ-033 guess_ready held 0 for 10 cycles in OFFER -> guess_valid stays 1 and guess0..3 stay constant throughout.
REQ-034 No macro: first guess 0000 scored black=0 white=0 -> next offer is 1,1,1,1 (cand=0x249); turn=1.
REQ-035 No macro: first guess scored black=3 white=1 -> full scan, then failed=1 with cand=4095 and no second offer.
REQ-036 MAX_TURNS=2: feedback black=0 white=0 given twice -> failed=1, turn=2, guess_valid=0.
REQ-037 start pulsed in WAIT_FB of turn 1 -> turn=0, history cleared, first guess re-offered; with the macro defined, that guess is 0,0,1,1.

Source files
------------

// File: rtl/auto_breaker.sv
// Four-slot, eight-colour code breaker: picks the lowest candidate consistent with every scored guess so far.
// Optional AUTO_BREAKER_OPENING_GUESS_EN: open each game with 0,0,1,1 instead of searching from 0,0,0,0.
module auto_breaker #(
  parameter int MAX_TURNS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] guess0,
  output logic [2:0] guess1,
  output logic [2:0] guess2,
  output logic [2:0] guess3,
  output logic       guess_valid,
  input  logic       guess_ready,
  input  logic       fb_valid,
  input  logic [2:0] fb_black,
  input  logic [2:0] fb_white,
  output logic       busy,
  output logic       solved,
  output logic       failed,
  output logic [3:0] turn
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEARCH  = 3'd1;
  localparam logic [2:0] OFFER   = 3'd2;
  localparam logic [2:0] WAIT_FB = 3'd3;
  localparam logic [2:0] SOLVED  = 3'd4;
  localparam logic [2:0] FAILED  = 3'd5;

  localparam logic [11:0] CAND_LAST = 12'hFFF;
  localparam logic [3:0]  TURN_LIM  = 4'(MAX_TURNS);
`ifdef AUTO_BREAKER_OPENING_GUESS_EN
  localparam logic [11:0] OPENING   = 12'h009;
`endif

  logic [2:0]  state;
  logic [11:0] cand;
  logic [2:0]  idx;
  logic [2:0]  turn_idx;
  logic [11:0] hist_guess [0:7];
  logic [2:0]  hist_black [0:7];
  logic [2:0]  hist_white [0:7];

  logic [5:0]  entry_score;
  logic        entry_match;
  logic        last_entry;
  logic [3:0]  turn_next;

  // Mastermind score packed as {black, white}; white is total colour overlap minus exact hits.
  function automatic logic [5:0] score(input logic [11:0] a, input logic [11:0] b);
    logic [2:0] black;
    logic [3:0] total;
    logic [2:0] ca;
    logic [2:0] cb;
    black = 3'd0;
    total = 4'd0;
    for (int s = 0; s < 4; s++)
      if (a[s*3 +: 3] == b[s*3 +: 3]) black = black + 3'd1;
    for (int c = 0; c < 8; c++) begin
      ca = 3'd0;
      cb = 3'd0;
      for (int s = 0; s < 4; s++) begin
        if (a[s*3 +: 3] == 3'(c)) ca = ca + 3'd1;
        if (b[s*3 +: 3] == 3'(c)) cb = cb + 3'd1;
      end
      total = total + {1'b0, (ca < cb) ? ca : cb};
    end
    return {black, 3'(total - {1'b0, black})};
  endfunction

  assign turn_idx    = turn[2:0];
  assign turn_next   = turn + 4'd1;
  assign entry_score = score(cand, hist_guess[idx]);
  assign entry_match = (entry_score == {hist_black[idx], hist_white[idx]});
  assign last_entry  = ({1'b0, idx} == (turn - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cand  <= 12'd0;
      turn  <= 4'd0;
      idx   <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        hist_guess[i] <= 12'd0;
        hist_black[i] <= 3'd0;
        hist_white[i] <= 3'd0;
      end
    end else if (start) begin
      turn <= 4'd0;
      idx  <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        hist_guess[i] <= 12'd0;
        hist_black[i] <= 3'd0;
        hist_white[i] <= 3'd0;
      end
`ifdef AUTO_BREAKER_OPENING_GUESS_EN
      cand  <= OPENING;
      state <= OFFER;
`else
      cand  <= 12'd0;
      state <= SEARCH;
`endif
    end else begin
      case (state)
        SEARCH: begin
          if (turn == 4'd0) begin
            state <= OFFER;
          end else if (entry_match) begin
            if (last_entry) begin
              idx   <= 3'd0;
              state <= OFFER;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            // Candidate space exhausted: stop rather than wrap back to 0.
            idx <= 3'd0;
            if (cand == CAND_LAST) state <= FAILED;
            else                   cand  <= cand + 12'd1;
          end
        end
        OFFER: begin
          if (guess_ready) begin
            hist_guess[turn_idx] <= cand;
            state                <= WAIT_FB;
          end
        end
        WAIT_FB: begin
          if (fb_valid) begin
            hist_black[turn_idx] <= fb_black;
            hist_white[turn_idx] <= fb_white;
            if (fb_black == 3'd4) begin
              state <= SOLVED;
            end else begin
              turn <= turn_next;
              if (turn_next == TURN_LIM || cand == CAND_LAST) begin
                state <= FAILED;
              end else begin
                cand  <= cand + 12'd1;
                state <= SEARCH;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign {guess3, guess2, guess1, guess0} = cand;
  assign guess_valid = (state == OFFER);
  assign busy        = (state == SEARCH) || (state == OFFER) || (state == WAIT_FB);
  assign solved      = (state == SOLVED);
  assign failed      = (state == FAILED);

endmodule

// File: tb/tb_auto_breaker.sv
// Directed bench for auto_breaker: single-guess outcome table plus hand sequences for
// handshake hold, reset priority, turn limit (second instance, MAX_TURNS=2) and restart.
module tb_auto_breaker;

  logic       clk = 1'b0;
  logic       reset, start, guess_ready, fb_valid;
  logic [2:0] fb_black, fb_white;
  logic [2:0] guess0, guess1, guess2, guess3;
  logic       guess_valid, busy, solved, failed;
  logic [3:0] turn;
  logic [2:0] g2_0, g2_1, g2_2, g2_3;
  logic       gv2, busy2, solved2, failed2;
  logic [3:0] turn2;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef AUTO_BREAKER_OPENING_GUESS_EN
  localparam logic [11:0] FIRST  = 12'h009;
  localparam logic [11:0] NEXT00 = 12'h492;
`else
  localparam logic [11:0] FIRST  = 12'h000;
  localparam logic [11:0] NEXT00 = 12'h249;
`endif

  always #5 clk = ~clk;

  auto_breaker #(.MAX_TURNS(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
    .guess_valid(guess_valid), .guess_ready(guess_ready),
    .fb_valid(fb_valid), .fb_black(fb_black), .fb_white(fb_white),
    .busy(busy), .solved(solved), .failed(failed), .turn(turn)
  );

  // Same stimulus as dut; diverges only once two turns have been used.
  auto_breaker #(.MAX_TURNS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start),
    .guess0(g2_0), .guess1(g2_1), .guess2(g2_2), .guess3(g2_3),
    .guess_valid(gv2), .guess_ready(guess_ready),
    .fb_valid(fb_valid), .fb_black(fb_black), .fb_white(fb_white),
    .busy(busy2), .solved(solved2), .failed(failed2), .turn(turn2)
  );

  typedef struct {
    logic [2:0]  b;
    logic [2:0]  w;
    logic        sol;
    logic        fail;
    logic [11:0] g;
    logic [3:0]  t;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] gval();
    return {guess3, guess2, guess1, guess0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic accept();
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
  endtask

  task automatic feedback(input logic [2:0] b, input logic [2:0] w);
    fb_valid = 1'b1;
    fb_black = b;
    fb_white = w;
    tick();
    fb_valid = 1'b0;
    fb_black = 3'd0;
    fb_white = 3'd0;
  endtask

  task automatic wait_offer(input string name, input int budget);
    int n = 0;
    while (!guess_valid && n < budget) begin
      tick();
      n++;
    end
    check({name, "_offer_reached"}, {31'd0, guess_valid}, 32'd1);
  endtask

  task automatic wait_settle(input string name, input int budget);
    int n = 0;
    while (!(guess_valid || solved || failed) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_settled"}, {31'd0, guess_valid | solved | failed}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; guess_ready = 1'b0;
    fb_valid = 1'b0; fb_black = 3'd0; fb_white = 3'd0;

    // Outcome of the very first guess for a given score.
`ifdef AUTO_BREAKER_OPENING_GUESS_EN
    vecs.push_back('{3'd4, 3'd0, 1'b1, 1'b0, 12'h009, 4'd0});
    vecs.push_back('{3'd0, 3'd0, 1'b0, 1'b0, 12'h492, 4'd1});
    vecs.push_back('{3'd2, 3'd2, 1'b0, 1'b0, 12'h041, 4'd1});
    vecs.push_back('{3'd3, 3'd1, 1'b0, 1'b1, 12'hFFF, 4'd1});
`else
    vecs.push_back('{3'd4, 3'd0, 1'b1, 1'b0, 12'h000, 4'd0});
    vecs.push_back('{3'd0, 3'd0, 1'b0, 1'b0, 12'h249, 4'd1});
    vecs.push_back('{3'd1, 3'd0, 1'b0, 1'b0, 12'h049, 4'd1});
    vecs.push_back('{3'd2, 3'd0, 1'b0, 1'b0, 12'h009, 4'd1});
    vecs.push_back('{3'd3, 3'd0, 1'b0, 1'b0, 12'h001, 4'd1});
    vecs.push_back('{3'd3, 3'd1, 1'b0, 1'b1, 12'hFFF, 4'd1});
    vecs.push_back('{3'd2, 3'd3, 1'b0, 1'b1, 12'hFFF, 4'd1});
`endif

    tick();
    tick();
    reset = 1'b0;
    check("rst_guess_valid", {31'd0, guess_valid}, 32'd0);
    check("rst_guess",       {20'd0, gval()},      32'd0);
    check("rst_busy",        {31'd0, busy},        32'd0);
    check("rst_solved",      {31'd0, solved},      32'd0);
    check("rst_failed",      {31'd0, failed},      32'd0);
    check("rst_turn",        {28'd0, turn},        32'd0);

    feedback(3'd4, 3'd0);
    check("idle_fb_ignored_solved", {31'd0, solved}, 32'd0);
    check("idle_fb_ignored_busy",   {31'd0, busy},   32'd0);

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      do_start();
      wait_offer(nm, 20);
      check({nm, "_first_guess"}, {20'd0, gval()}, {20'd0, FIRST});
      accept();
      check({nm, "_gv_after_accept"}, {31'd0, guess_valid}, 32'd0);
      feedback(vecs[i].b, vecs[i].w);
      wait_settle(nm, 5000);
      check({nm, "_solved"}, {31'd0, solved}, {31'd0, vecs[i].sol});
      check({nm, "_failed"}, {31'd0, failed}, {31'd0, vecs[i].fail});
      check({nm, "_turn"},   {28'd0, turn},   {28'd0, vecs[i].t});
      check({nm, "_guess"},  {20'd0, gval()}, {20'd0, vecs[i].g});
      check({nm, "_busy"},   {31'd0, busy},   {31'd0, !(vecs[i].sol || vecs[i].fail)});
      check({nm, "_gv"},     {31'd0, guess_valid}, {31'd0, !(vecs[i].sol || vecs[i].fail)});
    end

    // Terminal states hold without further input.
    repeat (5) tick();
    check("failed_held", {31'd0, failed}, {31'd0, vecs[vecs.size()-1].fail});
    check("never_both",  {31'd0, solved & failed}, 32'd0);

    // Offer held while consumer stalls.
    do_start();
    wait_offer("hold", 20);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("hold_gv_%0d", k),    {31'd0, guess_valid}, 32'd1);
      check($sformatf("hold_guess_%0d", k), {20'd0, gval()},      {20'd0, FIRST});
    end

    // Reset beats start mid-OFFER.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_offer_gv",   {31'd0, guess_valid}, 32'd0);
    check("rst_offer_busy", {31'd0, busy},        32'd0);

    // Reset mid-SEARCH during a long failing scan.
    do_start();
    wait_offer("rsearch", 20);
    accept();
    feedback(3'd3, 3'd1);
    repeat (50) tick();
    check("rsearch_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("rsearch_busy_after", {31'd0, busy},   32'd0);
    check("rsearch_guess",      {20'd0, gval()}, 32'd0);
    check("rsearch_turn",       {28'd0, turn},   32'd0);
    check("rsearch_failed",     {31'd0, failed}, 32'd0);

    // Turn limit of two on the second instance.
    do_start();
    wait_offer("lim", 20);
    accept();
    feedback(3'd0, 3'd0);
    wait_offer("lim2", 2000);
    check("lim_second_guess", {20'd0, gval()}, {20'd0, NEXT00});
    accept();
    feedback(3'd0, 3'd0);
    check("lim_failed2", {31'd0, failed2}, 32'd1);
    check("lim_turn2",   {28'd0, turn2},   32'd2);
    check("lim_gv2",     {31'd0, gv2},     32'd0);
    check("lim_solved2", {31'd0, solved2}, 32'd0);
    check("lim_dut_not_failed", {31'd0, failed}, 32'd0);

    // Restart from WAIT_FB of turn 1.
    do_start();
    wait_offer("rs", 20);
    accept();
    feedback(3'd0, 3'd0);
    wait_offer("rs2", 2000);
    accept();
    check("rs_turn_before", {28'd0, turn}, 32'd1);
    do_start();
    check("rs_turn_after", {28'd0, turn}, 32'd0);
    wait_offer("rs3", 20);
    check("rs_reoffer", {20'd0, gval()}, {20'd0, FIRST});

    // Start and feedback in the same cycle: feedback dropped.
    accept();
    start    = 1'b1;
    fb_valid = 1'b1;
    fb_black = 3'd4;
    tick();
    start    = 1'b0;
    fb_valid = 1'b0;
    fb_black = 3'd0;
    check("collide_solved", {31'd0, solved}, 32'd0);
    check("collide_busy",   {31'd0, busy},   32'd1);
    check("collide_turn",   {28'd0, turn},   32'd0);
    wait_offer("collide", 20);
    check("collide_reoffer", {20'd0, gval()}, {20'd0, FIRST});
    accept();
    feedback(3'd0, 3'd0);
    wait_offer("collide2", 2000);
    check("collide_next", {20'd0, gval()}, {20'd0, NEXT00});
    check("collide_turn1", {28'd0, turn}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
